// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shifter: operation codes, FSM states and a log2 helper.
package shifter_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/iter_shifter_shift_step.sv
// Combinational single step of the iterative shifter: shifts acc by k bits according to op.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [WIDTH-1:0]   acc,
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] k,
    output logic [WIDTH-1:0]   shifted
);

    always_comb begin
        shifted = acc;
        case (op)
            OP_SLL:  shifted = acc << k;
            OP_SRL:  shifted = acc >> k;
            OP_SRA:  shifted = $signed(acc) >>> k;
            // Low half of the doubled word shifted right is a rotate-right by k.
            default: shifted = WIDTH'({acc, acc} >> k);
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter moving up to STEP bits per clock under a start/busy/done handshake.
// Macro ITER_SHIFTER_ROTATE_EN enables op=11 as rotate-right; otherwise op=11 passes data through.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int STEP    = 1,
    localparam int SHAMT_W = clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   data_in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

`ifdef ITER_SHIFTER_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [1:0]         op_q, op_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [SHAMT_W-1:0] k;
    logic [WIDTH-1:0]   step_out;

    // A STEP that covers the whole word always finishes in one shift.
    generate
        if (STEP >= WIDTH) begin : g_full
            assign k = rem_q;
        end else begin : g_clip
            localparam logic [SHAMT_W-1:0] STEP_S = SHAMT_W'(STEP);
            assign k = (rem_q < STEP_S) ? rem_q : STEP_S;
        end
    endgenerate

    shift_step #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_step (
        .acc     (acc_q),
        .op      (op_q),
        .k       (k),
        .shifted (step_out)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        op_d     = op_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = data_in;
                    op_d    = op;
                    rem_d   = shamt;
                    if (op == OP_ROR && !ROT_EN) begin
                        rem_d = '0;
                    end
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (rem_q != '0) begin
                    acc_d = step_out;
                    rem_d = rem_q - k;
                end else begin
                    result_d = acc_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            rem_q    <= '0;
            op_q     <= OP_SLL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter: two instances (STEP=1 and STEP=4) with directed and random ops.
module tb_iter_shifter;

    localparam int W  = 32;
    localparam int SW = 5;

`ifdef ITER_SHIFTER_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
    } exp_t;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          start1  = 1'b0;
    logic          start4  = 1'b0;
    logic [1:0]    op      = 2'b00;
    logic [SW-1:0] shamt   = '0;
    logic [W-1:0]  data_in = '0;
    logic          busy1, done1, busy4, done4;
    logic [W-1:0]  result1, result4;

    int   cyc        = 0;
    int   compared   = 0;
    int   mismatched = 0;
    exp_t q1[$];
    exp_t q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iter_shifter #(.WIDTH(W), .STEP(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .op(op), .shamt(shamt), .data_in(data_in),
        .busy(busy1), .done(done1), .result(result1)
    );

    iter_shifter #(.WIDTH(W), .STEP(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .op(op), .shamt(shamt), .data_in(data_in),
        .busy(busy4), .done(done4), .result(result4)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [SW-1:0] s,
                                           input logic [W-1:0] d);
        logic signed [W-1:0] sd;
        sd = d;
        case (o)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return W'(sd >>> s);
            default: return ROT ? ((d >> s) | (d << (W - int'(s)))) : d;
        endcase
    endfunction

    // Drives one accepted request and queues its expected result and completion cycle.
    task automatic issue(input bit s4, input logic [1:0] o, input logic [SW-1:0] s,
                         input logic [W-1:0] d, input logic [W-1:0] exp_res, input string tag);
        exp_t e;
        int   step;
        int   lat;
        step = s4 ? 4 : 1;
        lat  = (o == 2'b11 && !ROT) ? 1 : (int'(s) + step - 1) / step + 1;
        op = o; shamt = s; data_in = d;
        if (s4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        e.res = exp_res;
        e.cyc = cyc + lat;
        if (s4) q4.push_back(e); else q1.push_back(e);
        check({tag, "_busy"}, {31'b0, (s4 ? busy4 : busy1)}, 32'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q1.size() != 0 || q4.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, 32'(q1.size() + q4.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done1) begin
            if (q1.size() == 0) begin
                check("s1_spurious_done", {31'b0, done1}, 32'd0);
            end else begin
                e = q1.pop_front();
                check("s1_result", result1, e.res);
                check("s1_latency", cyc, e.cyc);
                $display("step1 done: cyc=%0d result=0x%08h expected=0x%08h", cyc, result1, e.res);
            end
        end
        if (!rst && done4) begin
            if (q4.size() == 0) begin
                check("s4_spurious_done", {31'b0, done4}, 32'd0);
            end else begin
                e = q4.pop_front();
                check("s4_result", result4, e.res);
                check("s4_latency", cyc, e.cyc);
                $display("step4 done: cyc=%0d result=0x%08h expected=0x%08h", cyc, result4, e.res);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            n0;
        logic [1:0]    ro;
        logic [SW-1:0] rs;
        logic [W-1:0]  rd;

        repeat (2) @(negedge clk);
        check("rst_busy1",   {31'b0, busy1}, 32'd0);
        check("rst_done1",   {31'b0, done1}, 32'd0);
        check("rst_result1", result1, 32'd0);
        check("rst_busy4",   {31'b0, busy4}, 32'd0);
        check("rst_done4",   {31'b0, done4}, 32'd0);
        check("rst_result4", result4, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(1'b0, 2'b00, 5'd2, 32'h0000_0001, 32'h0000_0004, "sll2");
        drain("sll2");

        // Second start mid-operation with different operands must be ignored.
        issue(1'b0, 2'b10, 5'd4, 32'h8000_0000, 32'hF800_0000, "sra4");
        @(posedge clk); #1;
        start1 = 1'b1; op = 2'b00; shamt = 5'd1; data_in = 32'h0;
        @(posedge clk); #1;
        start1 = 1'b0;
        drain("sra4");

        issue(1'b1, 2'b01, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001, "srl31");
        n0 = cyc;
        while (cyc != n0 + 9) begin
            @(posedge clk); #1;
        end
        check("b2b_done_high", {31'b0, done4}, 32'd1);
        check("b2b_busy_low",  {31'b0, busy4}, 32'd0);
        issue(1'b1, 2'b01, 5'd0, 32'h1234_5678, 32'h1234_5678, "b2b_zero");
        drain("b2b");
        repeat (3) @(negedge clk);
        check("result_held", result4, 32'h1234_5678);

        issue(1'b0, 2'b00, 5'd20, 32'h0000_00A5, 32'h0A50_0000, "rst_sll");
        n0 = cyc;
        while (cyc != n0 + 5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("abort_busy1",   {31'b0, busy1}, 32'd0);
        check("abort_done1",   {31'b0, done1}, 32'd0);
        check("abort_result1", result1, 32'd0);
        check("abort_result4", result4, 32'd0);
        q1.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        issue(1'b0, 2'b00, 5'd3, 32'h0000_0003, 32'h0000_0018, "after_rst");
        drain("after_rst");

        issue(1'b0, 2'b11, 5'd1, 32'h0000_0001, ROT ? 32'h8000_0000 : 32'h0000_0001, "op11_s1");
        drain("op11_s1");
        issue(1'b1, 2'b11, 5'd1, 32'h0000_0001, ROT ? 32'h8000_0000 : 32'h0000_0001, "op11_s4");
        drain("op11_s4");

        issue(1'b1, 2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, "sra31");
        drain("sra31");
        issue(1'b0, 2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001, "srl31_s1");
        drain("srl31_s1");

        for (int i = 0; i < 10; i++) begin
            ro = 2'($urandom_range(0, 3));
            rs = 5'($urandom_range(0, 31));
            rd = $urandom;
            issue(i[0], ro, rs, rd, model(ro, rs, rd), "rand");
            drain("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
